// File: rtl/stored_program_controller.sv
// stored_program_controller: sole sequencer for the stored-program CPU.
// Fetches instructions from memory and steps through MOV, ALU, LDR and STR
// sequences. Memory accesses use a ready handshake with a per-access timeout.
// HALT and ERROR are terminal until reset.
//
// Parameters
//   MEM_TIMEOUT  maximum cycles in a memory-wait state before ERROR (0 = no timeout)
// Inputs
//   clk          sole clock, rising edge
//   rst_n        asynchronous reset, ACTIVE HIGH (1 = reset asserted)
//   opcode       IR[15:13]
//   ALU_op       IR[12:11]
//   mem_ready    memory completed the current read/write this cycle
// Outputs (all registered, Moore)
//   reg_sel      register index select: 00 Rm, 01 Rd, 10 Rn
//   wb_sel       write-back source: 00 mdata, 01 C, 10 sximm8
//   w_en, en_A, en_B, en_C, en_status, sel_A, sel_B   datapath controls
//   load_pc, clear_pc, load_ir, load_addr, addr_sel   PC/IR/address controls
//   mem_cmd      00 none, 01 read, 10 write
//   halted       high in HALT
//   error        high in ERROR
module stored_program_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic       mem_ready,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       error
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CntLast = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic TimeoutOn = (MEM_TIMEOUT > 0);

  // LDR and STR share ADDR_A/ADDR_C/LA behaviour but use separate states so the
  // path is remembered without re-sampling the opcode. Likewise GETB for MOV reg.
  typedef enum logic [4:0] {
    StReset, StIf, StUpd, StDec, StMovImm, StGetA, StGetB, StGetBMov, StAlu,
    StMovReg, StWrite, StLdAddrA, StLdAddrC, StLdLa, StLdMem, StLdWb,
    StStAddrA, StStAddrC, StStLa, StStB, StStC, StStMem, StHalt, StError
  } state_e;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_status;
    logic       sel_a;
    logic       sel_b;
    logic       load_pc;
    logic       clear_pc;
    logic       load_ir;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
    logic       error;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q;

  // Control word for a state. ALU_op is stable from UPD+1, so decoding it on
  // entry to ALU gives the same result as decoding it during ALU.
  function automatic ctrl_t decode(state_e s, logic [1:0] alu_op);
    ctrl_t c;
    c = '0;
    case (s)
      StReset:   begin c.clear_pc = 1'b1; c.load_pc = 1'b1; end
      StIf:      begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
      StUpd:     begin c.load_ir = 1'b1; c.load_pc = 1'b1; end
      StMovImm:  begin c.reg_sel = 2'b01; c.wb_sel = 2'b10; c.w_en = 1'b1; end
      StGetA,
      StLdAddrA,
      StStAddrA: begin c.reg_sel = 2'b10; c.en_a = 1'b1; end
      StGetB,
      StGetBMov: begin c.reg_sel = 2'b00; c.en_b = 1'b1; end
      StAlu: begin
        if (alu_op == 2'b01) c.en_status = 1'b1;
        else                 c.en_c = 1'b1;
      end
      StMovReg,
      StStC:     begin c.sel_a = 1'b1; c.en_c = 1'b1; end
      StWrite:   begin c.reg_sel = 2'b01; c.wb_sel = 2'b01; c.w_en = 1'b1; end
      StLdAddrC,
      StStAddrC: begin c.sel_b = 1'b1; c.en_c = 1'b1; end
      StLdLa,
      StStLa:    c.load_addr = 1'b1;
      StLdMem:   c.mem_cmd = 2'b01;
      StLdWb:    begin c.reg_sel = 2'b01; c.wb_sel = 2'b00; c.w_en = 1'b1; end
      StStB:     begin c.reg_sel = 2'b01; c.en_b = 1'b1; end
      StStMem:   c.mem_cmd = 2'b10;
      StHalt:    c.halted = 1'b1;
      StError:   c.error = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  logic is_wait;
  logic timeout_hit;
  state_e wait_exit;

  assign is_wait     = (state_q == StIf) || (state_q == StLdMem) || (state_q == StStMem);
  assign timeout_hit = TimeoutOn && (cnt_q == CntLast);

  always_comb begin
    state_d   = StError;
    cnt_d     = '0;
    wait_exit = StError;
    case (state_q)
      StReset:   state_d = StIf;
      StUpd:     state_d = StDec;
      StDec: begin
        case (opcode)
          3'b110: begin
            if (ALU_op == 2'b10)      state_d = StMovImm;
            else if (ALU_op == 2'b00) state_d = StGetBMov;
            else                      state_d = StError;
          end
          3'b101:  state_d = (ALU_op == 2'b11) ? StGetB : StGetA;
          3'b011:  state_d = (ALU_op == 2'b00) ? StLdAddrA : StError;
          3'b100:  state_d = (ALU_op == 2'b00) ? StStAddrA : StError;
          3'b111:  state_d = StHalt;
          default: state_d = StError;
        endcase
      end
      StMovImm:  state_d = StIf;
      StGetA:    state_d = StGetB;
      StGetB:    state_d = StAlu;
      StGetBMov: state_d = StMovReg;
      StMovReg:  state_d = StWrite;
      StAlu:     state_d = (ALU_op == 2'b01) ? StIf : StWrite;
      StWrite:   state_d = StIf;
      StLdAddrA: state_d = StLdAddrC;
      StLdAddrC: state_d = StLdLa;
      StLdLa:    state_d = StLdMem;
      StLdWb:    state_d = StIf;
      StStAddrA: state_d = StStAddrC;
      StStAddrC: state_d = StStLa;
      StStLa:    state_d = StStB;
      StStB:     state_d = StStC;
      StStC:     state_d = StStMem;
      StHalt:    state_d = StHalt;
      StError:   state_d = StError;
      StIf:      wait_exit = StUpd;
      StLdMem:   wait_exit = StLdWb;
      StStMem:   wait_exit = StIf;
      default:   state_d = StError;
    endcase

    // Common handshake/timeout handling for the three memory-wait states.
    if (is_wait) begin
      if (mem_ready) begin
        state_d = wait_exit;
      end else if (timeout_hit) begin
        state_d = StError;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StReset;
      cnt_q   <= '0;
      ctrl_q  <= decode(StReset, 2'b00);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode(state_d, ALU_op);
    end
  end

  assign reg_sel   = ctrl_q.reg_sel;
  assign wb_sel    = ctrl_q.wb_sel;
  assign w_en      = ctrl_q.w_en;
  assign en_A      = ctrl_q.en_a;
  assign en_B      = ctrl_q.en_b;
  assign en_C      = ctrl_q.en_c;
  assign en_status = ctrl_q.en_status;
  assign sel_A     = ctrl_q.sel_a;
  assign sel_B     = ctrl_q.sel_b;
  assign load_pc   = ctrl_q.load_pc;
  assign clear_pc  = ctrl_q.clear_pc;
  assign load_ir   = ctrl_q.load_ir;
  assign load_addr = ctrl_q.load_addr;
  assign addr_sel  = ctrl_q.addr_sel;
  assign mem_cmd   = ctrl_q.mem_cmd;
  assign halted    = ctrl_q.halted;
  assign error     = ctrl_q.error;

endmodule

// File: tb/tb_stored_program_controller.sv
// Scoreboard bench for stored_program_controller (MEM_TIMEOUT = 4).
// Stimulus pushes the expected output word for each cycle; a monitor pops and
// compares it 1 ns after the clock edge, or right after an async reset event.
module tb_stored_program_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       mem_ready;
  logic [1:0] reg_sel, wb_sel, mem_cmd;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic       load_pc, clear_pc, load_ir, load_addr, addr_sel, halted, error;

  stored_program_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ALU_op(ALU_op), .mem_ready(mem_ready),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
    .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
    .load_pc(load_pc), .clear_pc(clear_pc), .load_ir(load_ir), .load_addr(load_addr),
    .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  typedef enum {
    TReset, TIf, TUpd, TDec, TMovImm, TGetA, TGetB, TAluC, TAluS, TMovReg, TWrite,
    TAddrA, TAddrC, TLa, TLdMem, TLdWb, TStB, TStC, TStMem, THalt, TError
  } tst_e;

  typedef struct {
    string       nm;
    logic [19:0] v;
  } item_t;

  item_t      sb_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  event       async_ev;
  logic [2:0] cur_op;
  logic [1:0] cur_aop;

  logic [19:0] act;
  assign act = {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
                load_pc, clear_pc, load_ir, load_addr, addr_sel, mem_cmd, halted, error};

  // Expected output word per state, written out from the state/output table.
  function automatic logic [19:0] exp_vec(tst_e s);
    logic [1:0] rs, ws, mc;
    logic w, a, b, c, st, sa, sb, lp, cp, li, la, as, h, e;
    {rs, ws, mc} = '0;
    {w, a, b, c, st, sa, sb, lp, cp, li, la, as, h, e} = '0;
    case (s)
      TReset:  begin cp = 1; lp = 1; end
      TIf:     begin as = 1; mc = 2'b01; end
      TUpd:    begin li = 1; lp = 1; end
      TDec:    ;
      TMovImm: begin rs = 2'b01; ws = 2'b10; w = 1; end
      TGetA:   begin rs = 2'b10; a = 1; end
      TGetB:   begin rs = 2'b00; b = 1; end
      TAluC:   c = 1;
      TAluS:   st = 1;
      TMovReg: begin sa = 1; c = 1; end
      TWrite:  begin rs = 2'b01; ws = 2'b01; w = 1; end
      TAddrA:  begin rs = 2'b10; a = 1; end
      TAddrC:  begin sb = 1; c = 1; end
      TLa:     la = 1;
      TLdMem:  mc = 2'b01;
      TLdWb:   begin rs = 2'b01; ws = 2'b00; w = 1; end
      TStB:    begin rs = 2'b01; b = 1; end
      TStC:    begin sa = 1; c = 1; end
      TStMem:  mc = 2'b10;
      THalt:   h = 1;
      TError:  e = 1;
      default: ;
    endcase
    return {rs, ws, w, a, b, c, st, sa, sb, lp, cp, li, la, as, mc, h, e};
  endfunction

  // Monitor: one pop per clock edge (or async reset event) when work is queued.
  initial begin
    item_t it;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        n_vec++;
        if (act !== it.v) begin
          n_bad++;
          $display("FAIL %s: got %05h required %05h (t=%0t)", it.nm, act, it.v, $time);
        end
      end
    end
  end

  task automatic push(input string nm, input tst_e s);
    item_t it;
    it.nm = {nm, "/", s.name()};
    it.v  = exp_vec(s);
    sb_q.push_back(it);
  endtask

  // Drive inputs for the next rising edge; expect state s after that edge.
  task automatic cyc(input string nm, input logic r, input logic [2:0] op,
                     input logic [1:0] aop, input logic rdy, input tst_e s);
    @(negedge clk);
    rst_n     = r;
    opcode    = op;
    ALU_op    = aop;
    mem_ready = rdy;
    push(nm, s);
  endtask

  task automatic step(input string nm, input logic rdy, input tst_e s);
    cyc(nm, 1'b0, cur_op, cur_aop, rdy, s);
  endtask

  task automatic do_reset();
    cyc("reset", 1'b1, cur_op, cur_aop, 1'b0, TReset);
  endtask

  task automatic new_instr(input logic [2:0] op, input logic [1:0] aop);
    cur_op  = op;
    cur_aop = aop;
  endtask

  initial begin
    rst_n = 1'b1; opcode = '0; ALU_op = '0; mem_ready = 1'b0;
    cur_op = '0; cur_aop = '0;
    #1;
    push("por_async", TReset);
    -> async_ev;

    // Reset mid-wait, then check the timeout counter restarted from 0.
    cyc("rst_hold", 1'b1, 3'b000, 2'b00, 1'b0, TReset);
    cyc("rst_rel", 1'b0, 3'b000, 2'b00, 1'b0, TIf);
    step("if_wait2", 1'b0, TIf);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    push("midwait_async_rst", TReset);
    -> async_ev;
    cyc("rst_hold2", 1'b1, 3'b000, 2'b00, 1'b0, TReset);
    cyc("rst_rel2", 1'b0, 3'b000, 2'b00, 1'b0, TIf);
    repeat (3) step("if_cnt_restart", 1'b0, TIf);
    step("if_timeout", 1'b0, TError);
    repeat (2) cyc("err_hold", 1'b0, 3'($urandom), 2'($urandom), 1'b1, TError);

    // MOV imm.
    new_instr(3'b110, 2'b10);
    do_reset();
    step("mov_imm", 1'b1, TIf);
    step("mov_imm", 1'b1, TUpd);
    step("mov_imm", 1'b1, TDec);
    step("mov_imm", 1'b1, TMovImm);
    step("mov_imm", 1'b1, TIf);

    // ADD.
    new_instr(3'b101, 2'b00);
    step("add", 1'b1, TUpd);
    step("add", 1'b1, TDec);
    step("add", 1'b1, TGetA);
    step("add", 1'b1, TGetB);
    step("add", 1'b1, TAluC);
    step("add", 1'b1, TWrite);
    step("add", 1'b1, TIf);

    // CMP: status update only, no write-back.
    new_instr(3'b101, 2'b01);
    step("cmp", 1'b1, TUpd);
    step("cmp", 1'b1, TDec);
    step("cmp", 1'b1, TGetA);
    step("cmp", 1'b1, TGetB);
    step("cmp", 1'b1, TAluS);
    step("cmp", 1'b1, TIf);

    // MVN skips GETA.
    new_instr(3'b101, 2'b11);
    step("mvn", 1'b1, TUpd);
    step("mvn", 1'b1, TDec);
    step("mvn", 1'b1, TGetB);
    step("mvn", 1'b1, TAluC);
    step("mvn", 1'b1, TWrite);
    step("mvn", 1'b1, TIf);

    // MOV reg.
    new_instr(3'b110, 2'b00);
    step("mov_reg", 1'b1, TUpd);
    step("mov_reg", 1'b1, TDec);
    step("mov_reg", 1'b1, TGetB);
    step("mov_reg", 1'b1, TMovReg);
    step("mov_reg", 1'b1, TWrite);
    step("mov_reg", 1'b1, TIf);

    // LDR with 3 wait cycles in LD_MEM.
    new_instr(3'b011, 2'b00);
    step("ldr", 1'b1, TUpd);
    step("ldr", 1'b1, TDec);
    step("ldr", 1'b1, TAddrA);
    step("ldr", 1'b1, TAddrC);
    step("ldr", 1'b1, TLa);
    repeat (4) step("ldr_wait", 1'b0, TLdMem);
    step("ldr", 1'b1, TLdWb);
    step("ldr", 1'b1, TIf);

    // STR with mem_ready stuck low: timeout after 4 ST_MEM cycles.
    new_instr(3'b100, 2'b00);
    step("str_to", 1'b1, TUpd);
    step("str_to", 1'b1, TDec);
    step("str_to", 1'b1, TAddrA);
    step("str_to", 1'b1, TAddrC);
    step("str_to", 1'b1, TLa);
    step("str_to", 1'b1, TStB);
    step("str_to", 1'b1, TStC);
    repeat (4) step("str_to_wait", 1'b0, TStMem);
    step("str_to", 1'b0, TError);
    repeat (3) cyc("str_err_hold", 1'b0, 3'($urandom), 2'($urandom), 1'($urandom), TError);

    // STR with ready on the last allowed cycle completes normally.
    do_reset();
    step("str_ok", 1'b1, TIf);
    step("str_ok", 1'b1, TUpd);
    step("str_ok", 1'b1, TDec);
    step("str_ok", 1'b1, TAddrA);
    step("str_ok", 1'b1, TAddrC);
    step("str_ok", 1'b1, TLa);
    step("str_ok", 1'b1, TStB);
    step("str_ok", 1'b1, TStC);
    repeat (4) step("str_ok_wait", 1'b0, TStMem);
    step("str_ok", 1'b1, TIf);

    // HALT is terminal.
    new_instr(3'b111, 2'b00);
    step("halt", 1'b1, TUpd);
    step("halt", 1'b1, TDec);
    step("halt", 1'b1, THalt);
    repeat (20) cyc("halt_hold", 1'b0, 3'($urandom), 2'($urandom), 1'($urandom), THalt);

    // Illegal opcode 000.
    new_instr(3'b000, 2'b00);
    do_reset();
    step("illegal000", 1'b1, TIf);
    step("illegal000", 1'b1, TUpd);
    step("illegal000", 1'b1, TDec);
    step("illegal000", 1'b1, TError);
    repeat (3) step("illegal_hold", 1'b1, TError);

    // Illegal ALU_op under 110.
    new_instr(3'b110, 2'b01);
    do_reset();
    step("illegal110_01", 1'b1, TIf);
    step("illegal110_01", 1'b1, TUpd);
    step("illegal110_01", 1'b1, TDec);
    step("illegal110_01", 1'b1, TError);
    do_reset();
    step("after_err_rst", 1'b0, TIf);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
